if_stage_ibuf: RTL and testbench

//  Parametrised instruction-fetch stage for the LoongArch pipeline with a

---
 rtl/if_stage_ibuf.sv | 119 +++++++++++
 tb/tb_if_stage_ibuf.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_ibuf.sv
// Instruction-fetch stage: split req/resp inst-SRAM front end with a
// pc queue for in-flight fetches, an instruction buffer toward decode,
// and a cancel counter that drops stale responses after a redirect.
module if_stage_ibuf #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter int unsigned BR_BUS_WD       = 33,
  parameter int unsigned FS_TO_DS_BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  localparam int unsigned PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;
  localparam int unsigned OW = CW + 2;

  logic                       br_taken;
  logic [31:0]                br_target;
  logic [31:0]                fetch_pc;
  logic                       rst_hold;

  logic [31:0]                pcq_mem  [IBUF_DEPTH];
  logic [FS_TO_DS_BUS_WD-1:0] ibuf_mem [IBUF_DEPTH];
  logic [PW-1:0]              pcq_wr, pcq_rd, ibuf_wr, ibuf_rd;

  logic [CW-1:0]              pcq_cnt, ibuf_cnt, cancel_cnt;
  logic [CW-1:0]              pcq_cnt_nxt, ibuf_cnt_nxt, cancel_cnt_nxt;
  logic [OW-1:0]              occupancy;

  logic                       req_fire, resp_keep, resp_drop, ibuf_pop;

  assign br_taken       = br_bus[BR_BUS_WD-1];
  assign br_target      = br_bus[31:0];
  assign inst_sram_addr = fetch_pc;

  // Request/response/pop qualification from current occupancy
  always_comb begin
    occupancy      = OW'(pcq_cnt) + OW'(ibuf_cnt) + OW'(cancel_cnt);
    inst_sram_req  = !reset && !rst_hold && !br_taken && (occupancy < OW'(IBUF_DEPTH));
    req_fire       = inst_sram_req && inst_sram_addr_ok;
    resp_drop      = inst_sram_data_ok && (cancel_cnt != '0);
    resp_keep      = inst_sram_data_ok && (cancel_cnt == '0) && !br_taken;
    fs_to_ds_valid = !reset && (ibuf_cnt != '0) && !br_taken;
    ibuf_pop       = fs_to_ds_valid && ds_allowin;
    fs_to_ds_bus   = reset ? '0 : ibuf_mem[ibuf_rd];
  end

  // Counter next-state; a redirect turns every in-flight fetch into a cancel
  always_comb begin
    pcq_cnt_nxt    = pcq_cnt;
    ibuf_cnt_nxt   = ibuf_cnt;
    cancel_cnt_nxt = cancel_cnt;
    if (br_taken) begin
      pcq_cnt_nxt    = '0;
      ibuf_cnt_nxt   = '0;
      cancel_cnt_nxt = cancel_cnt + pcq_cnt - CW'(inst_sram_data_ok);
    end else begin
      pcq_cnt_nxt    = pcq_cnt + CW'(req_fire) - CW'(resp_keep);
      ibuf_cnt_nxt   = ibuf_cnt + CW'(resp_keep) - CW'(ibuf_pop);
      cancel_cnt_nxt = cancel_cnt - CW'(resp_drop);
    end
  end

  // Fetch pc, queues and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      rst_hold   <= 1'b1;
      pcq_wr     <= '0;
      pcq_rd     <= '0;
      ibuf_wr    <= '0;
      ibuf_rd    <= '0;
      pcq_cnt    <= '0;
      ibuf_cnt   <= '0;
      cancel_cnt <= '0;
      pcq_mem    <= '{default: '0};
      ibuf_mem   <= '{default: '0};
    end else begin
      rst_hold   <= 1'b0;
      pcq_cnt    <= pcq_cnt_nxt;
      ibuf_cnt   <= ibuf_cnt_nxt;
      cancel_cnt <= cancel_cnt_nxt;
      if (br_taken) begin
        fetch_pc <= br_target;
        pcq_rd   <= pcq_wr;
        ibuf_rd  <= ibuf_wr;
      end else begin
        if (req_fire) begin
          pcq_mem[pcq_wr] <= fetch_pc;
          pcq_wr          <= pcq_wr + PW'(1);
          fetch_pc        <= fetch_pc + 32'd4;
        end
        if (resp_keep) begin
          ibuf_mem[ibuf_wr] <= FS_TO_DS_BUS_WD'({inst_sram_rdata, pcq_mem[pcq_rd]});
          ibuf_wr           <= ibuf_wr + PW'(1);
          pcq_rd            <= pcq_rd + PW'(1);
        end
        if (ibuf_pop) begin
          ibuf_rd <= ibuf_rd + PW'(1);
        end
      end
    end
  end

  // Every response must belong to a tracked or a cancelled request
  assert property (@(posedge clk) disable iff (reset)
    !(inst_sram_data_ok && (pcq_cnt == '0) && (cancel_cnt == '0)));

endmodule

// File: tb/tb_if_stage_ibuf.sv
// Bench for if_stage_ibuf: in-order SRAM model with configurable latency
// plus a scoreboard of expected {inst, pc} deliveries to decode.
module tb_if_stage_ibuf;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata   = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // SRAM model knobs
  bit aok_en, aok_rand, hold_data, lat_rand;
  int lat_fix;

  // monitor state
  int          cyc = 0, hs_cnt = 0, dok_cnt = 0, pop_cnt = 0;
  logic [31:0] last_pop_pc = '0, last_pop_inst = '0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] sb[$];
  logic [63:0] sb_head;

  if_stage_ibuf dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // SRAM model drives at negedge+1; scoreboard samples at negedge+4
  always begin
    @(negedge clk);
    cyc++;
    #1;
    inst_sram_addr_ok = aok_en && (!aok_rand || ($urandom_range(0, 1) == 1));
    if (!reset && !hold_data && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(pend_addr[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'hdead_beef;
    end
    #3;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      sb.delete();
      exp_pc = RESET_PC;
    end else begin
      if (inst_sram_data_ok) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        dok_cnt++;
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        hs_cnt++;
        n_tests++;
        if (inst_sram_addr !== exp_pc) begin
          n_fail++;
          $display("FAIL fetch_addr: got %h expected %h", inst_sram_addr, exp_pc);
        end
        pend_addr.push_back(inst_sram_addr);
        pend_due.push_back(cyc + 1 + (lat_rand ? int'($urandom_range(0, 5)) : lat_fix));
        sb.push_back({inst_of(exp_pc), exp_pc});
        exp_pc = exp_pc + 32'd4;
      end
      if (br_bus[32]) begin
        n_tests++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b0) begin
          n_fail++;
          $display("FAIL redirect_quiet: valid=%b req=%b expected 0 0", fs_to_ds_valid, inst_sram_req);
        end
        sb.delete();
        exp_pc = br_bus[31:0];
      end
      if (fs_to_ds_valid && ds_allowin) begin
        pop_cnt++;
        last_pop_pc   = fs_to_ds_bus[31:0];
        last_pop_inst = fs_to_ds_bus[63:32];
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_delivery: got %h expected nothing", fs_to_ds_bus);
        end else begin
          sb_head = sb.pop_front();
          if (fs_to_ds_bus !== sb_head) begin
            n_fail++;
            $display("FAIL deliver: got %h expected %h", fs_to_ds_bus, sb_head);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    br_bus = '0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic wait_pop(input int p0);
    for (int i = 0; i < 60 && pop_cnt == p0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    ds_allowin = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #4;
      n_tests++;
      if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_to_ds_bus !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_hold: req=%b valid=%b bus=%h expected 0 0 0", inst_sram_req, fs_to_ds_valid, fs_to_ds_bus);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #4;
    n_tests++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_to_ds_bus !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_release: req=%b valid=%b bus=%h expected 0 0 0", inst_sram_req, fs_to_ds_valid, fs_to_ds_bus);
    end
    @(negedge clk);
    #4;
    n_tests++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h expected 1 %h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int p0, p1;
    lat_rand = 0; lat_fix = 0; aok_rand = 0; aok_en = 1; hold_data = 0; ds_allowin = 1;
    do_reset();
    p0 = pop_cnt;
    wait_pop(p0);
    n_tests++;
    if (pop_cnt - p0 !== 1 || last_pop_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_delivery: pops=%0d pc=%h expected 1 %h", pop_cnt - p0, last_pop_pc, RESET_PC);
    end
    p1 = pop_cnt;
    repeat (20) @(negedge clk);
    n_tests++;
    if (pop_cnt - p1 !== 20) begin
      n_fail++;
      $display("FAIL throughput: pops=%0d expected 20", pop_cnt - p1);
    end
  endtask

  task automatic test_random_latency();
    int p0;
    lat_rand = 1; aok_rand = 1; ds_allowin = 1;
    do_reset();
    p0 = pop_cnt;
    repeat (300) @(negedge clk);
    n_tests++;
    if (pop_cnt - p0 < 40) begin
      n_fail++;
      $display("FAIL random_progress: pops=%0d expected >=40", pop_cnt - p0);
    end
    lat_rand = 0; aok_rand = 0;
  endtask

  task automatic test_stall();
    int h0, p0, h1, p1, hs_d, pop_d;
    ds_allowin = 0;
    do_reset();
    h0 = hs_cnt; p0 = pop_cnt;
    repeat (20) @(negedge clk);
    hs_d = hs_cnt - h0; pop_d = pop_cnt - p0;
    #4;
    n_tests++;
    if (hs_d !== 4 || pop_d !== 0 || inst_sram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fill: handshakes=%0d pops=%0d req=%b expected 4 0 0", hs_d, pop_d, inst_sram_req);
    end
    @(negedge clk);
    ds_allowin = 1;
    h1 = hs_cnt; p1 = pop_cnt;
    repeat (8) @(negedge clk);
    n_tests++;
    if (pop_cnt - p1 < 4 || hs_cnt - h1 < 1) begin
      n_fail++;
      $display("FAIL stall_release: pops=%0d handshakes=%0d expected >=4 >=1", pop_cnt - p1, hs_cnt - h1);
    end
  endtask

  task automatic test_redirect();
    int h0, d0, d1, p0;
    logic [31:0] tgt;
    tgt = 32'h1c000100;
    ds_allowin = 0; hold_data = 1; aok_en = 1;
    do_reset();
    h0 = hs_cnt;
    for (int i = 0; i < 20 && hs_cnt - h0 < 3; i++) @(negedge clk);
    aok_en = 0;
    n_tests++;
    if (hs_cnt - h0 !== 3) begin
      n_fail++;
      $display("FAIL redirect_setup_req: handshakes=%0d expected 3", hs_cnt - h0);
    end
    d0 = dok_cnt;
    hold_data = 0;
    for (int i = 0; i < 20 && dok_cnt - d0 < 1; i++) @(negedge clk);
    hold_data = 1;
    n_tests++;
    if (dok_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL redirect_setup_resp: responses=%0d expected 1", dok_cnt - d0);
    end
    br_bus = {1'b1, tgt};
    ds_allowin = 1;
    d1 = dok_cnt;
    @(negedge clk);
    br_bus = '0; aok_en = 1; hold_data = 0;
    #4;
    n_tests++;
    if (fs_to_ds_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_flushed: valid=%b expected 0", fs_to_ds_valid);
    end
    p0 = pop_cnt;
    wait_pop(p0);
    n_tests++;
    if (last_pop_pc !== tgt || last_pop_inst !== inst_of(tgt) || dok_cnt - d1 < 3) begin
      n_fail++;
      $display("FAIL redirect_target: pc=%h inst=%h responses=%0d expected %h %h >=3",
               last_pop_pc, last_pop_inst, dok_cnt - d1, tgt, inst_of(tgt));
    end
  endtask

  task automatic test_back_to_back_redirect();
    int p0;
    logic [31:0] t1, t2;
    t1 = 32'h1c000200; t2 = 32'h1c000300;
    ds_allowin = 1; aok_en = 1; hold_data = 0; lat_fix = 0;
    do_reset();
    p0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt - p0 < 5; i++) @(negedge clk);
    br_bus = {1'b1, t1};
    #4;
    n_tests++;
    if (inst_sram_data_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_coincident: data_ok=%b expected 1", inst_sram_data_ok);
    end
    @(negedge clk);
    br_bus = {1'b1, t2};
    @(negedge clk);
    br_bus = '0;
    p0 = pop_cnt;
    wait_pop(p0);
    n_tests++;
    if (last_pop_pc !== t2) begin
      n_fail++;
      $display("FAIL b2b_target: pc=%h expected %h", last_pop_pc, t2);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    int h0, p0;
    ds_allowin = 0; hold_data = 1; aok_en = 1;
    do_reset();
    h0 = hs_cnt;
    for (int i = 0; i < 20 && hs_cnt - h0 < 3; i++) @(negedge clk);
    reset = 1'b1;
    #4;
    n_tests++;
    if (hs_cnt - h0 !== 3 || inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: handshakes=%0d req=%b valid=%b expected 3 0 0", hs_cnt - h0, inst_sram_req, fs_to_ds_valid);
    end
    @(negedge clk);
    reset = 1'b0; hold_data = 0; ds_allowin = 1;
    #4;
    n_tests++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_to_ds_bus !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_release: req=%b valid=%b bus=%h expected 0 0 0", inst_sram_req, fs_to_ds_valid, fs_to_ds_bus);
    end
    @(negedge clk);
    #4;
    n_tests++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_mid_restart: req=%b addr=%h expected 1 %h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
    p0 = pop_cnt;
    wait_pop(p0);
    n_tests++;
    if (last_pop_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_mid_delivery: pc=%h expected %h", last_pop_pc, RESET_PC);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b0; br_bus = '0;
    aok_en = 1; aok_rand = 0; hold_data = 0; lat_rand = 0; lat_fix = 0;
    test_reset();
    test_stream();
    test_random_latency();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
